// File: rtl/majority_pkg.sv
// Shared definitions for the majority-vote scheduler: default threshold,
// requester tag width and a bit-count helper used by the vote unit.
package majority_pkg;

    // Widest vote word the bit-count helper handles, and its count width
    localparam int MAX_W     = 64;
    localparam int MAX_CNT_W = 7;

    // Strict majority of the word bits
    function automatic int thresh_default(input int data_w);
        return data_w / 2 + 1;
    endfunction

    // Requester tag width; never narrower than one bit
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Unsigned count of set bits in a zero-extended word
    function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_W-1:0] w);
        logic [MAX_CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_W; i++) begin
            c = c + {{(MAX_CNT_W-1){1'b0}}, w[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/majority_core.sv
// Combinational majority vote: the output is 1 when the number of set bits
// in the word reaches THRESH. The scheduler registers this result.
module majority_core
    import majority_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int THRESH = thresh_default(DATA_W)
) (
    input  logic [DATA_W-1:0] word,
    output logic              vote
);

    logic [MAX_W-1:0]     wide;
    logic [MAX_CNT_W-1:0] count;

    // Zero-extend the word, count its ones and compare against the threshold
    always_comb begin
        wide               = '0;
        wide[DATA_W-1:0]   = word;
        count              = popcount(wide);
        vote               = (count >= MAX_CNT_W'(THRESH));
    end

endmodule

// File: rtl/majority_rr_sched.sv
// Round-robin scheduler sharing one majority-vote unit among NUM_REQ
// requesters. One grant per cycle; the vote and requester tag are held in a
// one-entry output slot with valid/ready backpressure.
module majority_rr_sched
    import majority_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int THRESH  = thresh_default(DATA_W),
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_y,
    output logic [ID_W-1:0]           res_id,
    output logic [15:0]               grant_cnt
);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   next_ptr;
    logic              found;
    logic              slot_free;
    logic              transfer;
    logic [DATA_W-1:0] sel_word;
    logic              vote;

    // Rotating-priority search: first valid requester starting at rr_ptr
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found     = 1'b1;
                grant_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // One-hot grant, only when the slot can take a result and not in reset
    always_comb begin
        slot_free = !res_valid || res_ready;
        req_ready = '0;
        if (!rst && slot_free && found) begin
            req_ready[grant_idx] = 1'b1;
        end
        transfer = |req_ready;
        sel_word = req_data[int'(grant_idx)*DATA_W +: DATA_W];
        next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
    end

    majority_core #(
        .DATA_W (DATA_W),
        .THRESH (THRESH)
    ) u_core (
        .word (sel_word),
        .vote (vote)
    );

    // Output slot, round-robin pointer and grant counter
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_y     <= 1'b0;
            res_id    <= '0;
            grant_cnt <= '0;
            rr_ptr    <= '0;
        end else if (transfer) begin
            res_valid <= 1'b1;
            res_y     <= vote;
            res_id    <= grant_idx;
            grant_cnt <= grant_cnt + 16'd1;
            rr_ptr    <= next_ptr;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_majority_rr_sched.sv
// Self-checking bench for majority_rr_sched: directed stimulus pushes the
// expected {id, vote} of every grant into a queue; a monitor pops and compares
// each result as the consumer accepts it.
module tb_majority_rr_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic        res_y;
    logic [1:0]  res_id;
    logic [15:0] grant_cnt;

    logic [2:0]  expQ[$];
    int          numChecks;
    int          numFails;

    majority_rr_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_id    (res_id),
        .grant_cnt (grant_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic rr);
        req_valid = v;
        req_data  = d;
        res_ready = rr;
    endtask

    // Move to the drive point just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // At mid-cycle check the grant; record the expected result if one is granted
    task automatic expectGrant(input logic [3:0] expReady, input logic [1:0] id, input logic y);
        @(negedge clk);
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        if (expReady != 4'b0000) expQ.push_back({id, y});
        tick();
    endtask

    // Monitor: compare each accepted result against the oldest expectation
    always @(negedge clk) begin
        logic [2:0] e;
        if (!rst && res_valid && res_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 32'({res_id, res_y}), 32'h7);
            end else begin
                e = expQ.pop_front();
                checkOutput("res_id", 32'(res_id), 32'(e[2:1]));
                checkOutput("res_y", 32'(res_y), 32'(e[0]));
            end
        end
    end

    initial begin
        numChecks = 0;
        numFails  = 0;
        rst       = 1'b1;
        applyStimulus(4'b1111, 32'hFFFF_FFFF, 1'b1);

        // Reset hold with every requester valid
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
            checkOutput("rst_res_valid", 32'(res_valid), 32'h0);
            checkOutput("rst_grant_cnt", 32'(grant_cnt), 32'h0);
        end
        tick();
        rst = 1'b0;

        // Single requester 0, back-to-back words
        applyStimulus(4'b0001, 32'h0000_000F, 1'b1); expectGrant(4'b0001, 2'd0, 1'b0);
        applyStimulus(4'b0001, 32'h0000_0019, 1'b1); expectGrant(4'b0001, 2'd0, 1'b0);
        applyStimulus(4'b0001, 32'h0000_005F, 1'b1); expectGrant(4'b0001, 2'd0, 1'b1);
        applyStimulus(4'b0001, 32'h0000_0005, 1'b1); expectGrant(4'b0001, 2'd0, 1'b0);
        applyStimulus(4'b0001, 32'h0000_0003, 1'b1); expectGrant(4'b0001, 2'd0, 1'b0);
        applyStimulus(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("grant_cnt_after_5", 32'(grant_cnt), 32'd5);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // All valid: r0=0x00, r1=0xFF, r2=0x1F, r3=0x0F, rotating grants
        applyStimulus(4'b1111, 32'h0F1F_FF00, 1'b1);
        expectGrant(4'b0001, 2'd0, 1'b0);
        expectGrant(4'b0010, 2'd1, 1'b1);
        expectGrant(4'b0100, 2'd2, 1'b1);
        expectGrant(4'b1000, 2'd3, 1'b0);
        expectGrant(4'b0001, 2'd0, 1'b0);
        applyStimulus(4'b0000, 32'h0, 1'b1);
        tick();

        // Backpressure: hold a result from requester 2 while requester 1 waits
        applyStimulus(4'b0100, 32'h00FF_0000, 1'b1);
        expectGrant(4'b0100, 2'd2, 1'b1);
        applyStimulus(4'b0010, 32'h0000_FF00, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("hold_req_ready", 32'(req_ready), 32'h0);
            checkOutput("hold_res_valid", 32'(res_valid), 32'h1);
            checkOutput("hold_res_y", 32'(res_y), 32'h1);
            checkOutput("hold_res_id", 32'(res_id), 32'h2);
            tick();
        end
        res_ready = 1'b1;
        expectGrant(4'b0010, 2'd1, 1'b1);
        applyStimulus(4'b0000, 32'h0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Counter wrap: 65535 transfers, then one more
        applyStimulus(4'b0001, 32'h0, 1'b1);
        for (int n = 0; n < 65535; n++) begin
            expQ.push_back({2'd0, 1'b0});
            tick();
        end
        applyStimulus(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("grant_cnt_ffff", 32'(grant_cnt), 32'hFFFF);
        tick();
        applyStimulus(4'b0001, 32'h0000_00FF, 1'b1);
        expectGrant(4'b0001, 2'd0, 1'b1);
        applyStimulus(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("grant_cnt_wrap", 32'(grant_cnt), 32'h0);
        tick();

        // Reset while a result is pending; its vote is discarded
        applyStimulus(4'b0100, 32'h00FF_0000, 1'b1);
        @(negedge clk);
        checkOutput("pre_rst_grant", 32'(req_ready), 32'h4);
        tick();
        applyStimulus(4'b0000, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("pre_rst_res_valid", 32'(res_valid), 32'h1);
        tick();
        rst = 1'b1;
        applyStimulus(4'b1111, 32'h0F1F_FF00, 1'b0);
        @(negedge clk);
        checkOutput("rst_cycle_req_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(4'b1010, 32'h0F00_1F00, 1'b1);
        @(negedge clk);
        checkOutput("post_rst_res_valid", 32'(res_valid), 32'h0);
        checkOutput("post_rst_grant", 32'(req_ready), 32'h2);
        expQ.push_back({2'd1, 1'b1});
        tick();
        applyStimulus(4'b0000, 32'h0, 1'b1);
        tick();
        tick();
        checkOutput("results_outstanding", 32'(expQ.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
